// File: rtl/frog_pkg.sv
// Shared types and constants for the frog game controller.
package frog_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_NONE  = 8'h00;

    localparam logic [COORD_W-1:0] RIVER_TOP_DEF = 11'd40;
    localparam logic [COORD_W-1:0] RIVER_BOT_DEF = 11'd200;
    localparam logic [COORD_W-1:0] GOAL_Y_DEF    = 11'd32;
    localparam logic [COORD_W-1:0] LOG_HW_DEF    = 11'd24;
    localparam logic [COORD_W-1:0] LOG_HH_DEF    = 11'd16;
    localparam logic [CNT_W-1:0]   DIE_TICKS_DEF = 8'd60;
    localparam logic [LIVES_W-1:0] START_LIVES   = 2'd3;

endpackage

// File: rtl/frame_tick.sv
// Rising-edge detector turning the frame strobe level into a one-Clk tick.
module frame_tick (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic frame_clk_q;
    logic frame_clk_d;

    always_comb begin
        frame_clk_d = frame_clk;
    end

    // Tracks the strobe during reset too, so a strobe already high at release is not a tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_q <= frame_clk;
        end else begin
            frame_clk_q <= frame_clk_d;
        end
    end

    assign tick = frame_clk & ~frame_clk_q;

endmodule

// File: rtl/frog_game_fsm.sv
// Game controller: start, goal scoring, drowning, death animation and game over.
module frog_game_fsm
    import frog_pkg::*;
#(
    parameter logic [COORD_W-1:0] RIVER_TOP = RIVER_TOP_DEF,
    parameter logic [COORD_W-1:0] RIVER_BOT = RIVER_BOT_DEF,
    parameter logic [COORD_W-1:0] GOAL_Y    = GOAL_Y_DEF,
    parameter logic [COORD_W-1:0] LOG_HW    = LOG_HW_DEF,
    parameter logic [COORD_W-1:0] LOG_HH    = LOG_HH_DEF,
    parameter logic [CNT_W-1:0]   DIE_TICKS = DIE_TICKS_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [7:0]         keycode,
    input  logic [COORD_W-1:0] FrogX,
    input  logic [COORD_W-1:0] FrogY,
    input  logic [COORD_W-1:0] LogX,
    input  logic [COORD_W-1:0] LogY,
    output logic [1:0]         GameState,
    output logic [LIVES_W-1:0] Lives,
    output logic [SCORE_W-1:0] Score,
    output logic               FrogRespawn
);

    localparam int unsigned SUM_W = COORD_W + 1;

    logic tick;

    game_state_t        state_q,   state_d;
    logic [LIVES_W-1:0] lives_q,   lives_d;
    logic [SCORE_W-1:0] score_q,   score_d;
    logic [CNT_W-1:0]   die_cnt_q, die_cnt_d;
    logic               respawn_q, respawn_d;

    logic on_log;
    logic in_river;
    logic at_goal;

    frame_tick u_frame_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // Overlap test widened by one bit so the +half-size sums cannot wrap.
    always_comb begin
        on_log = (SUM_W'(FrogX) + SUM_W'(LOG_HW) >= SUM_W'(LogX)) &&
                 (SUM_W'(FrogX) <= SUM_W'(LogX) + SUM_W'(LOG_HW)) &&
                 (SUM_W'(FrogY) + SUM_W'(LOG_HH) >= SUM_W'(LogY)) &&
                 (SUM_W'(FrogY) <= SUM_W'(LogY) + SUM_W'(LOG_HH));
        in_river = (FrogY >= RIVER_TOP) && (FrogY <= RIVER_BOT);
        at_goal  = (FrogY <= GOAL_Y);
    end

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        die_cnt_d = die_cnt_q;
        respawn_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (keycode == KEY_ENTER) begin
                    state_d   = ST_PLAY;
                    lives_d   = START_LIVES;
                    score_d   = '0;
                    respawn_d = 1'b1;
                end
            end
            // Positions are stale while a respawn reload is in flight, so skip that cycle.
            ST_PLAY: begin
                if (tick && !respawn_q) begin
                    if (at_goal) begin
                        if (score_q != {SCORE_W{1'b1}}) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        respawn_d = 1'b1;
                    end else if (in_river && !on_log) begin
                        state_d   = ST_DYING;
                        die_cnt_d = DIE_TICKS;
                        if (lives_q != '0) begin
                            lives_d = lives_q - LIVES_W'(1);
                        end
                    end
                end
            end
            ST_DYING: begin
                if (tick) begin
                    if (die_cnt_q <= CNT_W'(1)) begin
                        die_cnt_d = '0;
                        if (lives_q == '0) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d   = ST_PLAY;
                            respawn_d = 1'b1;
                        end
                    end else begin
                        die_cnt_d = die_cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (tick && keycode == KEY_NONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            lives_q   <= '0;
            score_q   <= '0;
            die_cnt_q <= '0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            die_cnt_q <= die_cnt_d;
            respawn_q <= respawn_d;
        end
    end

    assign GameState   = state_q;
    assign Lives       = lives_q;
    assign Score       = score_q;
    assign FrogRespawn = respawn_q;

endmodule

// File: tb/tb_frog_game_fsm.sv
// Directed bench for frog_game_fsm with hand-computed expectations.
module tb_frog_game_fsm;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [7:0]  keycode;
    logic [10:0] FrogX, FrogY, LogX, LogY;
    logic [1:0]  GameState;
    logic [1:0]  Lives;
    logic [7:0]  Score;
    logic        FrogRespawn;

    int n_checks = 0;
    int n_errors = 0;
    int resp_cnt = 0;
    int back2back = 0;
    logic resp_prev = 1'b0;
    int base;

    frog_game_fsm dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .FrogX       (FrogX),
        .FrogY       (FrogY),
        .LogX        (LogX),
        .LogY        (LogY),
        .GameState   (GameState),
        .Lives       (Lives),
        .Score       (Score),
        .FrogRespawn (FrogRespawn)
    );

    always #5 Clk = ~Clk;

    // Pulse bookkeeping for respawn counting and back-to-back detection.
    always @(posedge Clk) begin
        if (FrogRespawn) resp_cnt = resp_cnt + 1;
        if (FrogRespawn && resp_prev) back2back = back2back + 1;
        resp_prev = FrogRespawn;
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // One frame: strobe high for a cycle (the tick), then low for a cycle.
    task automatic frame();
        frame_clk = 1'b1;
        step(1);
        frame_clk = 1'b0;
        step(1);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
        FrogX = 11'd300; FrogY = 11'd300; LogX = 11'd100; LogY = 11'd100;
        step(2);
        Reset = 1'b0;
        step(1);
        check("reset_state", GameState, 0);
        check("reset_lives", Lives, 0);
        check("reset_score", Score, 0);
        check("reset_respawn", FrogRespawn, 0);

        // Start game
        base = resp_cnt;
        keycode = 8'h28;
        step(1);
        keycode = 8'h00;
        check("start_state", GameState, 1);
        check("start_lives", Lives, 3);
        check("start_score", Score, 0);
        check("start_respawn_hi", FrogRespawn, 1);
        step(2);
        check("start_respawn_cnt", resp_cnt - base, 1);

        // Drown far off the log
        FrogX = 11'd300; FrogY = 11'd100;
        frame();
        check("drown1_state", GameState, 2);
        check("drown1_lives", Lives, 2);
        base = resp_cnt;
        frames(59);
        check("dying_59_state", GameState, 2);
        frame();
        check("dying_60_state", GameState, 1);
        check("dying_respawn_cnt", resp_cnt - base, 1);

        // Right edge of the log still counts as riding it
        FrogX = 11'd124; FrogY = 11'd100;
        frames(10);
        check("onlog_state", GameState, 1);
        check("onlog_lives", Lives, 2);
        FrogX = 11'd125;
        frame();
        check("offlog_state", GameState, 2);
        check("offlog_lives", Lives, 1);
        frames(60);
        check("drown2_back_state", GameState, 1);

        // Goals: score increments per tick, one respawn each
        FrogX = 11'd300; FrogY = 11'd30;
        base = resp_cnt;
        frame();
        check("goal1_score", Score, 1);
        frames(2);
        check("goal3_score", Score, 3);
        check("goal3_respawn_cnt", resp_cnt - base, 3);
        FrogY = 11'd32;
        frames(252);
        check("goal_sat_score", Score, 255);
        frame();
        check("goal_sat_hold", Score, 255);
        check("goal_sat_state", GameState, 1);
        FrogY = 11'd33;
        frame();
        check("above_river_score", Score, 255);
        check("above_river_state", GameState, 1);

        // Third drown at river top edge leads to game over
        FrogY = 11'd40;
        frame();
        check("drown3_state", GameState, 2);
        check("drown3_lives", Lives, 0);
        frames(60);
        check("over_state", GameState, 3);
        check("over_lives", Lives, 0);
        check("over_score", Score, 255);
        keycode = 8'h05;
        frame();
        check("over_key_held", GameState, 3);
        keycode = 8'h00;
        frame();
        check("over_to_idle", GameState, 0);

        // New game, drown at river bottom edge, reset mid-death with a coincident tick
        keycode = 8'h28;
        step(1);
        keycode = 8'h00;
        check("restart_lives", Lives, 3);
        check("restart_score", Score, 0);
        step(1);
        FrogY = 11'd200; FrogX = 11'd300;
        frame();
        check("drown4_state", GameState, 2);
        check("drown4_lives", Lives, 2);
        frames(30);
        check("mid_dying_state", GameState, 2);
        Reset = 1'b1; frame_clk = 1'b1;
        step(1);
        check("rst_mid_state", GameState, 0);
        check("rst_mid_lives", Lives, 0);
        check("rst_mid_respawn", FrogRespawn, 0);
        step(1);
        Reset = 1'b0;
        step(2);
        check("post_rst_state", GameState, 0);
        check("post_rst_score", Score, 0);
        frame_clk = 1'b0;
        step(1);

        check("no_back_to_back_respawn", back2back, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frog_game_fsm.md
FROG_GAME_FSM -- requirements
Module: frog_game_fsm

Interface
REQ-001 SHALL have parameter RIVER_TOP, default 11'd40, meaning the top Y bound of the river band (inclusive).
REQ-002 SHALL have parameter RIVER_BOT, default 11'd200, meaning the bottom Y bound of the river band (inclusive).
REQ-003 SHALL have parameter GOAL_Y, default 11'd32, meaning the frog scores when FrogY <= GOAL_Y.
REQ-004 SHALL have parameter LOG_HW, default 11'd24, meaning the log half-width in X.
REQ-005 SHALL have parameter LOG_HH, default 11'd16, meaning the log half-height in Y.
REQ-006 SHALL have parameter DIE_TICKS, default 8'd60, meaning the length of the death animation in frame ticks.
REQ-007 SHALL have port Clk, input, 1 bit: the system clock; the block has one clock.
REQ-008 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port frame_clk, input, 1 bit: frame strobe, a level synchronous to Clk; a frame tick is its rising edge.
REQ-010 SHALL have port keycode, input, 8 bits: the current USB keycode.
REQ-011 SHALL have ports FrogX and FrogY, input, 11 bits each: the frog centre from the frog motion stage.
REQ-012 SHALL have ports LogX and LogY, input, 11 bits each: the log centre from the frog motion stage.
REQ-013 SHALL have port GameState, output, 2 bits: IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-014 SHALL have port Lives, output, 2 bits: lives remaining.
REQ-015 SHALL have port Score, output, 8 bits: goals reached, saturating at 255.
REQ-016 SHALL have port FrogRespawn, output, 1 bit: a one-Clk pulse that commands the motion stage to reload the frog start position.

Function
REQ-017 SHALL generate tick = frame_clk AND NOT frame_clk_q, where frame_clk_q is frame_clk registered on Clk.
REQ-018 SHALL evaluate all game conditions only in a Clk cycle where tick=1; all outputs hold between ticks.
REQ-019 SHALL, in IDLE, go to PLAY when keycode==8'h28 (Enter), with Lives=3, Score=0 and FrogRespawn=1 in the same transition cycle; the keycode is sampled every Clk, not only on ticks.
REQ-020 SHALL define on_log = (FrogX+LOG_HW >= LogX) && (FrogX <= LogX+LOG_HW) && (FrogY+LOG_HH >= LogY) && (FrogY <= LogY+LOG_HH), using 12-bit unsigned sums so there is no wrap.
REQ-021 SHALL define in_river = RIVER_TOP <= FrogY <= RIVER_BOT.
REQ-022 SHALL, in PLAY on a tick with FrogY <= GOAL_Y, set Score to Score+1 (saturating at 255) and pulse FrogRespawn, and stay in PLAY; the goal check has priority over the drown check.
REQ-023 SHALL, in PLAY on a tick with in_river && !on_log, go to DYING, decrement Lives by 1, and load the death counter with DIE_TICKS.
REQ-024 SHALL, in DYING, decrement the counter once per tick and ignore keycode and positions.
REQ-025 SHALL, on the tick that brings the counter to 0, go to OVER if Lives==0; otherwise go to PLAY with FrogRespawn=1 in that cycle.
REQ-026 SHALL, in OVER, hold Score and go to IDLE when keycode==8'h00 (all keys released).
REQ-027 SHALL keep FrogRespawn high for exactly one Clk cycle per event and never assert it in two consecutive cycles.
REQ-028 SHALL never decrement Lives below 0; a drown is impossible with Lives==0 because the FSM leaves PLAY first.

Reset
REQ-029 SHALL, while Reset=1 at a Clk edge, set GameState=IDLE, Lives=0, Score=0, FrogRespawn=0, the death counter to 0, and frame_clk_q to 0.
REQ-030 SHALL give Reset priority over every transition, including mid-DYING and a tick coincident with Reset.
REQ-031 SHALL suppress any tick in the first cycle after Reset deasserts if frame_clk is already high at that point (frame_clk_q=0 is acceptable only if frame_clk was low during reset; otherwise frame_clk_q tracks frame_clk during reset).

Structure
REQ-032 SHALL place the state enum (game_state_t), the Enter/release keycode constants, and the field-geometry defaults in the shared package frog_pkg.
REQ-033 SHALL implement the tick generator as sub-module frame_tick (Clk, Reset, frame_clk -> tick).
REQ-034 SHALL use a single always_ff for state/counters and an always_comb for next-state logic.

Verification
REQ-035 SHALL cover: Reset, then keycode=8'h28 for 1 Clk -> GameState=1, Lives=3, Score=0, exactly one FrogRespawn pulse.
REQ-036 SHALL cover: PLAY, FrogY=100, FrogX=300, LogX=100, LogY=100, one tick -> GameState=2, Lives=2; after 60 further ticks -> GameState=1 with one FrogRespawn pulse.
REQ-037 SHALL cover: PLAY, FrogY=100, FrogX=LogX+24, FrogY=LogY, 10 ticks -> GameState stays 1 and Lives unchanged; FrogX=LogX+25 -> DYING on the next tick.
REQ-038 SHALL cover: PLAY, FrogY=30 -> Score increments on each tick with one FrogRespawn per tick; at Score=255, a further goal keeps Score=255.
REQ-039 SHALL cover: three drowns -> after the third death animation GameState=3, Lives=0; keycode=8'h00 -> GameState=0.
REQ-040 SHALL cover: Reset asserted with GameState=2 and the counter at 30 -> next cycle GameState=0, Lives=0, no FrogRespawn.
